seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
// Scan scheduler for the 4-digit multiplexed 7-segment display. Holds a double-buffered
// 4-entry frame of raw segment patterns and time-shares the common segment bus between
// digits. Adds an anti-ghost blanking gap, per-digit enable mask and 3-bit brightness PWM.
// Sits between the application (pattern writer) and the seg_dat/seg_sel board pins.
// PARAMETERS
// CLK_HZ     25_000_000  input clock frequency
// SCAN_HZ    1000        digit slot rate; PRESCALE = CLK_HZ/SCAN_HZ clocks per slot
// BLANK_CYC  250         clocks of forced blank at start of every slot (anti-ghost)
// PORTS
// clk        in   1  system clock
// nRst       in   1  reset, asynchronous, active-high (1 = reset)
// enable     in   1  1 = scan running; 0 = display blank, scanner idle
// bright     in   3  brightness 0..7; sampled at slot start
// en_mask    in   4  bit i = 1 enables digit i; sampled at slot start
// wr_valid   in   1  pattern write request
// wr_ready   out  1  write accepted when wr_valid & wr_ready
// wr_addr    in   2  digit index 0..3 (0 = leftmost, seg_sel 4'b0111)
// wr_data    in   8  raw segment pattern, driven to seg_dat unmodified
// wr_commit  in   1  request shadow->active swap at next frame boundary
// commit_pend out 1  swap requested, not yet done
// frame_sync out  1  1-clk pulse when digit 0 slot starts
// seg_dat    out  8  segment bus (registered)
// seg_sel    out  4  digit select, active-low, one-cold (registered)
// BEHAVIOUR
// - Reset: shadow/active buffers 0, seg_dat=8'h00, seg_sel=4'b1111, wr_ready=1,
//   commit_pend=0, frame_sync=0, state IDLE, digit=0, slot count=0.
// - FSM: IDLE -> BLANK (enable=1). Per slot: BLANK (BLANK_CYC clks) -> ON (on_len clks)
//   -> OFF (remaining clks; skipped if 0) -> BLANK of next digit. Slot = PRESCALE clks exactly.
// - on_len = ((PRESCALE-BLANK_CYC)>>3)*(bright+1); elaboration error if PRESCALE-BLANK_CYC<8.
// - Output is 1 clk behind state: in ON, seg_dat=active[digit], seg_sel=~(4'b1000>>digit);
//   in IDLE/BLANK/OFF, or ON with en_mask[digit]=0: seg_dat=8'h00, seg_sel=4'b1111.
// - Digit advances 0,1,2,3,0 at slot end. Disabled digits keep their slot time (blank),
//   so frame period is always 4*PRESCALE.
// - Frame boundary = entry to BLANK of digit 0 (incl. leaving IDLE): frame_sync=1 that clk;
//   if commit_pend, active<=shadow same clk, commit_pend<=0.
// - Write: wr_valid&wr_ready -> shadow[wr_addr]<=wr_data next clk. wr_ready=~commit_pend.
// - wr_commit accepted when wr_ready=1 (with or without wr_valid); same-cycle write lands
//   in shadow before the swap. wr_commit while commit_pend=1 is ignored.
// - enable 1->0 mid-slot: next clk state IDLE, digit=0, count=0, outputs blank; buffers and
//   commit_pend retained. While IDLE, a pending commit swaps immediately (next clk).
// - nRst mid-operation: all state to reset values asynchronously, pending commit lost.
// STRUCTURE
// - Include file seg_scan_defs.vh: state encodings (IDLE/BLANK/ON/OFF), NUM_DIG=4,
//   SEG_BLANK=8'h00, SEL_NONE=4'b1111.
// - Sub-module seg_slot_timer: counter 0..PRESCALE-1, outputs slot_end, blank_end,
//   on_end (from latched bright). Buffers, handshake, FSM and output regs in top.
// TESTING (CLK_HZ=1000, SCAN_HZ=100 -> PRESCALE=10, BLANK_CYC=2, on_len=bright+1)
// 1 Reset, enable=0, write addr0..3 = 8'hFE,8'hBA,8'hBA,8'h62 + commit -> outputs stay
//   8'h00/4'b1111, commit_pend 1 then 0 one clk later.
// 2 enable=1, bright=7, mask=4'hF -> per 10-clk slot: 2 clks blank then 8 clks
//   FE/0111, BA/1011, BA/1101, 62/1110; frame_sync every 40 clks.
// 3 bright=0 -> each slot 2 blank, 1 on, 7 off; change bright mid-slot -> takes effect
//   next slot only.
// 4 en_mask=4'b1010 -> digits 1,3 blank for whole slot; frame period still 40 clks.
// 5 Write 8'h11 @addr2 + commit mid-frame -> wr_ready=0 till next frame_sync; old BA shown
//   until then, 11 from next frame; wr_valid during pend not accepted; 2nd commit ignored.
// 6 Drop enable mid-ON, then nRst pulse mid-ON -> blank next clk / immediately; restart
//   begins with frame_sync at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package seg_scan_ctrl_pkg;

  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned DIG_W   = 2;
  localparam int unsigned SEG_W   = 8;

  localparam logic [SEG_W-1:0]   SEG_BLANK = 8'h00;
  localparam logic [NUM_DIG-1:0] SEL_NONE  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } scan_state_e;

  // Active-low one-cold select; digit 0 is the leftmost (MSB) position.
  function automatic logic [NUM_DIG-1:0] sel_for(input logic [DIG_W-1:0] dig);
    sel_for = ~(4'b1000 >> dig);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter 0..PRESCALE-1 with registered phase-end flags for the scan FSM.
module seg_slot_timer #(
  parameter int unsigned PRESCALE  = 10,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       run,
  input  logic       start,
  input  logic [2:0] bright,
  output logic       slot_end,
  output logic       blank_end,
  output logic       on_end
);

  localparam int unsigned CNT_W   = $clog2(PRESCALE);
  localparam int unsigned ON_UNIT = (PRESCALE - BLANK_CYC) >> 3;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       bright_q;
  logic [2:0]       bright_n;

  // Last count of the ON phase for a given brightness.
  function automatic logic [CNT_W-1:0] on_last_f(input logic [2:0] b);
    on_last_f = CNT_W'(BLANK_CYC - 1 + ON_UNIT * (32'(b) + 32'd1));
  endfunction

  always_comb begin
    cnt_n    = cnt;
    bright_n = bright_q;
    if (start) bright_n = bright;
    if (!run || cnt == SLOT_LAST) cnt_n = '0;
    else                          cnt_n = cnt + CNT_W'(1);
  end

  // Flags are decoded from the next count so they line up with cnt.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      cnt       <= '0;
      bright_q  <= '0;
      slot_end  <= 1'b0;
      blank_end <= 1'b0;
      on_end    <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      bright_q  <= bright_n;
      slot_end  <= (cnt_n == SLOT_LAST);
      blank_end <= (cnt_n == BLANK_LAST);
      on_end    <= (cnt_n == on_last_f(bright_n));
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan scheduler: double-buffered frame, anti-ghost blanking,
// per-digit enable mask and 3-bit brightness PWM.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 250
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               enable,
  input  logic [2:0]         bright,
  input  logic [NUM_DIG-1:0] en_mask,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DIG_W-1:0]   wr_addr,
  input  logic [SEG_W-1:0]   wr_data,
  input  logic               wr_commit,
  output logic               commit_pend,
  output logic               frame_sync,
  output logic [SEG_W-1:0]   seg_dat,
  output logic [NUM_DIG-1:0] seg_sel
);

  localparam int unsigned PRESCALE = CLK_HZ / SCAN_HZ;

  if (BLANK_CYC < 1 || PRESCALE < BLANK_CYC + 8) begin : g_bad_param
    $error("seg_scan_ctrl: need BLANK_CYC >= 1 and PRESCALE - BLANK_CYC >= 8");
  end

  scan_state_e        state, state_n;
  logic [DIG_W-1:0]   digit, digit_n;
  logic [NUM_DIG-1:0] mask_q;
  logic [SEG_W-1:0]   shadow [NUM_DIG];
  logic [SEG_W-1:0]   active [NUM_DIG];

  logic               slot_end, blank_end, on_end;
  logic               run, slot_start, frame_start, swap, show;
  logic               wr_fire, commit_fire, commit_pend_n;
  logic [SEG_W-1:0]   seg_dat_n;
  logic [NUM_DIG-1:0] seg_sel_n;

  assign run = (state != ST_IDLE) && enable;

  seg_slot_timer #(
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .nRst      (nRst),
    .run       (run),
    .start     (slot_start),
    .bright    (bright),
    .slot_end  (slot_end),
    .blank_end (blank_end),
    .on_end    (on_end)
  );

  // Next state, slot/frame boundaries, commit handshake and output values.
  always_comb begin
    state_n       = state;
    digit_n       = digit;
    slot_start    = 1'b0;
    frame_start   = 1'b0;
    swap          = 1'b0;
    show          = 1'b0;
    wr_fire       = wr_valid && wr_ready;
    commit_fire   = wr_commit && wr_ready;
    commit_pend_n = commit_pend;
    seg_dat_n     = SEG_BLANK;
    seg_sel_n     = SEL_NONE;

    case (state)
      ST_IDLE:  if (enable) begin
                  state_n    = ST_BLANK;
                  slot_start = 1'b1;
                end
      ST_BLANK: if (blank_end) state_n = ST_ON;
      ST_ON:    if (on_end) begin
                  if (slot_end) begin
                    state_n    = ST_BLANK;
                    slot_start = 1'b1;
                  end else begin
                    state_n = ST_OFF;
                  end
                end
      ST_OFF:   if (slot_end) begin
                  state_n    = ST_BLANK;
                  slot_start = 1'b1;
                end
      default:  state_n = ST_IDLE;
    endcase

    if (state != ST_IDLE && !enable) begin
      state_n    = ST_IDLE;
      digit_n    = '0;
      slot_start = 1'b0;
    end else if (slot_start && state != ST_IDLE) begin
      digit_n = digit + DIG_W'(1);
    end

    frame_start = slot_start && (state == ST_IDLE || digit == DIG_W'(NUM_DIG - 1));
    swap        = commit_pend && (state == ST_IDLE || frame_start);
    if (swap)        commit_pend_n = 1'b0;
    if (commit_fire) commit_pend_n = 1'b1;

    // Gating with enable blanks the pins on the same edge the FSM drops to IDLE.
    show = (state == ST_ON) && enable && mask_q[digit];
    if (show) begin
      seg_dat_n = active[digit];
      seg_sel_n = sel_for(digit);
    end
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state       <= ST_IDLE;
      digit       <= '0;
      mask_q      <= '0;
      commit_pend <= 1'b0;
      wr_ready    <= 1'b1;
      frame_sync  <= 1'b0;
      seg_dat     <= SEG_BLANK;
      seg_sel     <= SEL_NONE;
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state       <= state_n;
      digit       <= digit_n;
      commit_pend <= commit_pend_n;
      wr_ready    <= ~commit_pend_n;
      frame_sync  <= frame_start;
      seg_dat     <= seg_dat_n;
      seg_sel     <= seg_sel_n;
      if (slot_start) mask_q <= en_mask;
      if (wr_fire)    shadow[wr_addr] <= wr_data;
      if (swap) begin
        for (int i = 0; i < NUM_DIG; i++) active[i] <= shadow[i];
      end
    end
  end

endmodule
